fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 20, SRAM word-address width (matches the timer's 20-bit pixel address).
REQ-002 Parameter DATA_W, default 16, SRAM data width.
REQ-003 Parameter MAX_DISP_RUN, default 4, consecutive display grants allowed while a write waits (range 1..15).
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 disp_req  in  1  display fetch request; held high until disp_ack.
REQ-007 disp_addr  in  ADDR_W  display read address, stable while disp_req high.
REQ-008 disp_ack  out  1  one-cycle pulse: display request accepted.
REQ-009 disp_valid  out  1  one-cycle pulse: disp_rdata holds new read data.
REQ-010 disp_rdata  out  DATA_W  last read word; held between reads.
REQ-011 wr_req  in  1  writer request; held high until wr_ack.
REQ-012 wr_addr  in  ADDR_W  write address, stable while wr_req high.
REQ-013 wr_data  in  DATA_W  write data, stable while wr_req high.
REQ-014 wr_ack  out  1  one-cycle pulse: write accepted.
REQ-015 sram_ce  out  1  SRAM chip enable.
REQ-016 sram_we  out  1  SRAM write enable (valid only with sram_ce).
REQ-017 sram_addr  out  ADDR_W  SRAM address.
REQ-018 sram_wdata  out  DATA_W  SRAM write data.
REQ-019 sram_rdata  in  DATA_W  SRAM read data, valid at end of second access cycle.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 FSM states SHALL be IDLE, RD1, RD2, WR1, WR2; all outputs registered.
REQ-022 IDLE: grant evaluated each cycle; display grant -> RD1, write grant -> WR1, none -> stay IDLE.
REQ-023 Default priority: display over writer when both requests are high in IDLE.
REQ-024 On grant, address (and write data) SHALL be latched; sram_addr/sram_wdata drive latched values for both access cycles.
REQ-025 RD1, RD2: sram_ce=1, sram_we=0; WR1, WR2: sram_ce=1, sram_we=1; IDLE: sram_ce=0, sram_we=0.
REQ-026 disp_ack high exactly during RD1; wr_ack high exactly during WR1.
REQ-027 At end of RD2, sram_rdata captured into disp_rdata; disp_valid high the following cycle (IDLE).
REQ-028 RD2 and WR2 SHALL return to IDLE; back-to-back accesses therefore spaced 3 cycles (grant cycle + 2 access cycles).
REQ-029 Read latency: request seen in IDLE at cycle T -> disp_ack at T+1 -> disp_valid at T+3.
REQ-030 Request dropped before ack: no access if low in IDLE evaluation; once granted, access completes regardless.
REQ-031 Never more than one ack pulse per grant; never simultaneous disp_ack and wr_ack.

Reset
REQ-032 rst high SHALL immediately force IDLE and all outputs to 0 (disp_rdata = 0, busy = 0).
REQ-033 Reset mid-access SHALL abandon the access with no disp_valid/ack afterwards; starvation counter cleared.
REQ-034 First grant evaluation occurs on first rising clk edge after rst deasserts.

Configuration
REQ-035 Macro FB_ARB_STARVE_GUARD_EN defined: 4-bit counter counts display grants made while wr_req high; when count equals MAX_DISP_RUN, next IDLE grant goes to writer if wr_req high; counter clears on write grant or when wr_req low in IDLE.
REQ-036 Macro undefined: strict display priority, no counter logic; writer may starve indefinitely.

Verification
REQ-037 Single read: disp_req=1, disp_addr=0x00010, sram_rdata=0xBEEF -> disp_ack at T+1, disp_valid at T+3, disp_rdata=0xBEEF, sram_we=0 throughout.
REQ-038 Single write: wr_req=1, wr_addr=0x12345, wr_data=0xA5A5 -> wr_ack at T+1, sram_ce=sram_we=1 for 2 cycles, sram_addr=0x12345, sram_wdata=0xA5A5.
REQ-039 Collision: disp_req and wr_req rise same cycle -> read granted first, write acked 3 cycles later.
REQ-040 Starvation (guard on, MAX_DISP_RUN=4): disp_req and wr_req held high -> 4 reads, then 1 write, pattern repeats; guard off -> 0 writes over 100 cycles.
REQ-041 Reset mid-RD2: rst pulse -> sram_ce=0 immediately, no disp_valid, disp_rdata=0, busy=0, next request serviced normally.
REQ-042 Hold: disp_rdata retains 0xBEEF across 10 idle cycles and across an intervening write.

Source files
------------

// File: rtl/fb_arbiter.sv
// Frame-buffer SRAM arbiter: display reads vs. writer accesses, two-cycle SRAM accesses.
// Optional write-starvation guard enabled by defining FB_ARB_STARVE_GUARD_EN.
module fb_arbiter #(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned MAX_DISP_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              valid_nxt;
  logic              force_wr;

  if (MAX_DISP_RUN < 1 || MAX_DISP_RUN > 15) begin : g_param_check
    $error("fb_arbiter: MAX_DISP_RUN must be in 1..15");
  end

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = 4;
  logic [CNT_W-1:0] run_cnt, run_cnt_nxt;

  assign force_wr = (run_cnt == CNT_W'(MAX_DISP_RUN));
`else
  assign force_wr = 1'b0;
`endif

  // Next-state and next-output decode; outputs are registered from these values.
  always_comb begin
    state_nxt = state;
    addr_nxt  = sram_addr;
    wdata_nxt = sram_wdata;
    rdata_nxt = disp_rdata;
    valid_nxt = 1'b0;
`ifdef FB_ARB_STARVE_GUARD_EN
    run_cnt_nxt = run_cnt;
`endif
    unique case (state)
      IDLE: begin
`ifdef FB_ARB_STARVE_GUARD_EN
        if (!wr_req) run_cnt_nxt = '0;
`endif
        if (wr_req && (!disp_req || force_wr)) begin
          state_nxt = WR1;
          addr_nxt  = wr_addr;
          wdata_nxt = wr_data;
`ifdef FB_ARB_STARVE_GUARD_EN
          run_cnt_nxt = '0;
`endif
        end else if (disp_req) begin
          state_nxt = RD1;
          addr_nxt  = disp_addr;
`ifdef FB_ARB_STARVE_GUARD_EN
          if (wr_req) run_cnt_nxt = run_cnt + CNT_W'(1);
`endif
        end
      end
      RD1: state_nxt = RD2;
      RD2: begin
        state_nxt = IDLE;
        rdata_nxt = sram_rdata;
        valid_nxt = 1'b1;
      end
      WR1: state_nxt = WR2;
      WR2: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset forces everything to zero immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      disp_ack   <= 1'b0;
      wr_ack     <= 1'b0;
      disp_valid <= 1'b0;
      disp_rdata <= '0;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      disp_ack   <= (state_nxt == RD1);
      wr_ack     <= (state_nxt == WR1);
      disp_valid <= valid_nxt;
      disp_rdata <= rdata_nxt;
      sram_ce    <= (state_nxt != IDLE);
      sram_we    <= (state_nxt == WR1) || (state_nxt == WR2);
      sram_addr  <= addr_nxt;
      sram_wdata <= wdata_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

`ifdef FB_ARB_STARVE_GUARD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_cnt <= '0;
    else     run_cnt <= run_cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: scenario tasks plus a read/write scoreboard monitor.
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_req;
  logic [19:0] disp_addr;
  logic        disp_ack;
  logic        disp_valid;
  logic [15:0] disp_rdata;
  logic        wr_req;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        sram_ce;
  logic        sram_we;
  logic [19:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] rd_q[$];
  logic [35:0] wr_q[$];
  logic [15:0] rd_exp;
  logic [35:0] wr_exp;

  fb_arbiter #(.ADDR_W(20), .DATA_W(16), .MAX_DISP_RUN(4)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_valid(disp_valid), .disp_rdata(disp_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Scoreboard: pop expected read data on disp_valid, expected write on wr_ack.
  always @(negedge clk) begin
    total++;
    if (disp_ack && wr_ack) begin
      bad++;
      $display("FAIL ack_exclusive: disp_ack=%b wr_ack=%b, required not both", disp_ack, wr_ack);
    end
    if (disp_valid) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_sb: unexpected disp_valid, rdata=%h", disp_rdata);
      end else begin
        rd_exp = rd_q.pop_front();
        if (disp_rdata !== rd_exp) begin
          bad++;
          $display("FAIL rd_sb: disp_rdata=%h expected=%h", disp_rdata, rd_exp);
        end
      end
    end
    if (wr_ack) begin
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL wr_sb: unexpected wr_ack, addr=%h data=%h", sram_addr, sram_wdata);
      end else begin
        wr_exp = wr_q.pop_front();
        if ({sram_addr, sram_wdata} !== wr_exp || sram_we !== 1'b1 || sram_ce !== 1'b1) begin
          bad++;
          $display("FAIL wr_sb: addr=%h data=%h ce=%b we=%b expected addr=%h data=%h ce=1 we=1",
                   sram_addr, sram_wdata, sram_ce, sram_we, wr_exp[35:16], wr_exp[15:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; disp_req = 1'b0; wr_req = 1'b0;
    disp_addr = '0; wr_addr = '0; wr_data = '0; sram_rdata = '0;
    #1 rst = 1'b1;
    #2;
    total++;
    if ({disp_ack, disp_valid, disp_rdata, wr_ack, sram_ce, sram_we, sram_addr, sram_wdata, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: ack=%b valid=%b rdata=%h wack=%b ce=%b we=%b addr=%h wd=%h busy=%b, required all 0",
               disp_ack, disp_valid, disp_rdata, wr_ack, sram_ce, sram_we, sram_addr, sram_wdata, busy);
    end
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_read();
    sram_rdata = 16'hBEEF; disp_addr = 20'h00010; disp_req = 1'b1;
    rd_q.push_back(16'hBEEF);
    step();
    total++;
    if ({disp_ack, wr_ack, sram_ce, sram_we, busy, sram_addr} !== {5'b10101, 20'h00010}) begin
      bad++;
      $display("FAIL read_rd1: ack=%b wack=%b ce=%b we=%b busy=%b addr=%h, required 1 0 1 0 1 00010",
               disp_ack, wr_ack, sram_ce, sram_we, busy, sram_addr);
    end
    disp_req = 1'b0;
    step();
    total++;
    if ({disp_ack, disp_valid, sram_ce, sram_we, sram_addr} !== {4'b0010, 20'h00010}) begin
      bad++;
      $display("FAIL read_rd2: ack=%b valid=%b ce=%b we=%b addr=%h, required 0 0 1 0 00010",
               disp_ack, disp_valid, sram_ce, sram_we, sram_addr);
    end
    step();
    total++;
    if ({disp_valid, sram_ce, sram_we, busy, disp_rdata} !== {4'b1000, 16'hBEEF}) begin
      bad++;
      $display("FAIL read_valid: valid=%b ce=%b we=%b busy=%b rdata=%h, required 1 0 0 0 beef",
               disp_valid, sram_ce, sram_we, busy, disp_rdata);
    end
    sram_rdata = 16'h0000;
    step();
    total++;
    if (disp_valid !== 1'b0) begin
      bad++;
      $display("FAIL read_valid_pulse: valid=%b, required 0", disp_valid);
    end
  endtask

  task automatic test_write();
    wr_addr = 20'h12345; wr_data = 16'hA5A5; wr_req = 1'b1;
    wr_q.push_back({20'h12345, 16'hA5A5});
    step();
    total++;
    if ({wr_ack, disp_ack, sram_ce, sram_we, sram_addr, sram_wdata} !== {4'b1011, 20'h12345, 16'hA5A5}) begin
      bad++;
      $display("FAIL write_wr1: wack=%b ack=%b ce=%b we=%b addr=%h wd=%h, required 1 0 1 1 12345 a5a5",
               wr_ack, disp_ack, sram_ce, sram_we, sram_addr, sram_wdata);
    end
    wr_req = 1'b0;
    step();
    total++;
    if ({wr_ack, sram_ce, sram_we, sram_addr, sram_wdata} !== {3'b011, 20'h12345, 16'hA5A5}) begin
      bad++;
      $display("FAIL write_wr2: wack=%b ce=%b we=%b addr=%h wd=%h, required 0 1 1 12345 a5a5",
               wr_ack, sram_ce, sram_we, sram_addr, sram_wdata);
    end
    step();
    total++;
    if ({sram_ce, sram_we, busy, disp_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL write_done: ce=%b we=%b busy=%b valid=%b, required 0 0 0 0",
               sram_ce, sram_we, busy, disp_valid);
    end
  endtask

  task automatic test_collision();
    int rd_at = -1;
    int wr_at = -1;
    sram_rdata = 16'hBEEF;
    disp_addr = 20'h00020; disp_req = 1'b1;
    wr_addr = 20'h00777; wr_data = 16'h1357; wr_req = 1'b1;
    rd_q.push_back(16'hBEEF);
    wr_q.push_back({20'h00777, 16'h1357});
    for (int i = 1; i <= 10; i++) begin
      step();
      if (disp_ack) begin rd_at = i; disp_req = 1'b0; end
      if (wr_ack)   begin wr_at = i; wr_req = 1'b0; end
    end
    total++;
    if (rd_at != 1 || wr_at != 4) begin
      bad++;
      $display("FAIL collision_order: disp_ack at %0d wr_ack at %0d, required 1 and 4", rd_at, wr_at);
    end
  endtask

  task automatic test_hold();
    int drift = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (disp_rdata !== 16'hBEEF) drift++;
    end
    total++;
    if (drift != 0) begin
      bad++;
      $display("FAIL hold_idle: rdata=%h changed in %0d cycles, required beef", disp_rdata, drift);
    end
    sram_rdata = 16'h0F0F;
    wr_addr = 20'h00300; wr_data = 16'h2468; wr_req = 1'b1;
    wr_q.push_back({20'h00300, 16'h2468});
    step();
    wr_req = 1'b0;
    step(); step(); step();
    total++;
    if (disp_rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL hold_write: rdata=%h, required beef", disp_rdata);
    end
  endtask

  task automatic test_starvation();
    int rd_n = 0;
    int wr_n = 0;
    logic [9:0] seq = '0;
    int seq_n = 0;
    sram_rdata = 16'h1234;
    disp_addr = 20'h00040; disp_req = 1'b1;
    wr_addr = 20'h00050; wr_data = 16'h9999; wr_req = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (disp_ack) begin
        rd_n++;
        rd_q.push_back(16'h1234);
        if (seq_n < 10) begin seq[seq_n] = 1'b0; seq_n++; end
      end
      if (wr_ack) begin
        wr_n++;
        wr_q.push_back({20'h00050, 16'h9999});
        if (seq_n < 10) begin seq[seq_n] = 1'b1; seq_n++; end
      end
    end
    disp_req = 1'b0; wr_req = 1'b0;
`ifdef FB_ARB_STARVE_GUARD_EN
    total++;
    if (seq_n != 10 || seq !== 10'b10000_10000) begin
      bad++;
      $display("FAIL starve_pattern: first grants (bit0 first, 1=write)=%b n=%0d, required 1000010000", seq, seq_n);
    end
    total++;
    if (rd_n + wr_n != 34 || wr_n < 6) begin
      bad++;
      $display("FAIL starve_counts: reads=%0d writes=%0d, required 34 grants with >=6 writes", rd_n, wr_n);
    end
`else
    total++;
    if (wr_n != 0 || rd_n != 34 || seq_n != 10) begin
      bad++;
      $display("FAIL starve_strict: reads=%0d writes=%0d, required 34 reads and 0 writes", rd_n, wr_n);
    end
`endif
    for (int i = 0; i < 10 && busy; i++) step();
    step(); step();
    total++;
    if (busy !== 1'b0 || rd_q.size() != 0 || wr_q.size() != 0) begin
      bad++;
      $display("FAIL starve_drain: busy=%b pending reads=%0d writes=%0d, required 0 0 0",
               busy, rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int got_valid = 0;
    sram_rdata = 16'h4444; disp_addr = 20'h00060; disp_req = 1'b1;
    rd_q.push_back(16'h4444);
    step();
    disp_req = 1'b0;
    step();
    total++;
    if ({sram_ce, busy, disp_rdata} !== {2'b11, 16'h1234}) begin
      bad++;
      $display("FAIL reset_mid_pre: ce=%b busy=%b rdata=%h, required 1 1 1234", sram_ce, busy, disp_rdata);
    end
    rst = 1'b1;
    rd_q.delete();
    #1;
    total++;
    if ({sram_ce, sram_we, busy, disp_valid, disp_ack, disp_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_mid: ce=%b we=%b busy=%b valid=%b ack=%b rdata=%h, required all 0",
               sram_ce, sram_we, busy, disp_valid, disp_ack, disp_rdata);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (disp_valid || disp_ack) got_valid++;
    end
    total++;
    if (got_valid != 0) begin
      bad++;
      $display("FAIL reset_mid_quiet: %0d cycles with valid/ack after reset, required 0", got_valid);
    end
    sram_rdata = 16'hCAFE; disp_addr = 20'h00ABC; disp_req = 1'b1;
    rd_q.push_back(16'hCAFE);
    step();
    total++;
    if ({disp_ack, sram_addr} !== {1'b1, 20'h00ABC}) begin
      bad++;
      $display("FAIL reset_mid_next_ack: ack=%b addr=%h, required 1 00abc", disp_ack, sram_addr);
    end
    disp_req = 1'b0;
    step(); step();
    total++;
    if ({disp_valid, disp_rdata} !== {1'b1, 16'hCAFE}) begin
      bad++;
      $display("FAIL reset_mid_next_valid: valid=%b rdata=%h, required 1 cafe", disp_valid, disp_rdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    step();
    test_read();
    test_write();
    test_collision();
    test_hold();
    test_starvation();
    test_reset_mid();
    step(); step();
    total++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      bad++;
      $display("FAIL sb_empty: pending reads=%0d writes=%0d, required 0 0", rd_q.size(), wr_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
